// File: rtl/sdk_ep_pkg.sv
// Shared defaults and channel FSM encoding for the SDK host endpoint.
package sdk_ep_pkg;

    localparam int SDK_DW = 16;
    localparam int SDK_AW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SWITCH = 2'd2
    } ch_state_e;

endpackage

// File: rtl/sdk_sync_fifo.sv
// FWFT synchronous FIFO with registered count, empty/full and one programmable almost flag.
// ALMOST_LOW=1: almost_o = count <= LVL; ALMOST_LOW=0: almost_o = count >= depth - LVL.
module sdk_sync_fifo
    import sdk_ep_pkg::*;
#(
    parameter int DW         = SDK_DW,
    parameter int AW         = SDK_AW,
    parameter int LVL        = 2,
    parameter bit ALMOST_LOW = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          almost_o
);

    localparam int DEPTH   = 1 << AW;
    localparam int ALM_THR = ALMOST_LOW ? ((LVL > DEPTH) ? DEPTH : LVL)
                                        : ((LVL >= DEPTH) ? 0 : DEPTH - LVL);
    localparam logic [AW:0] THR_V   = (AW+1)'(ALM_THR);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_V   = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
    logic          empty_q, empty_d, full_q, full_d, almost_q, almost_d;
    logic          wr_en, rd_en;

    // Push+pop on full or empty moves both pointers, so the count is unchanged.
    assign wr_en = push_i & (~full_q | pop_i);
    assign rd_en = pop_i & (~empty_q | push_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + ONE_V;
        if (rd_en) rd_ptr_d = rd_ptr_q + ONE_V;
        if (wr_en && !rd_en) cnt_d = cnt_q + ONE_V;
        if (rd_en && !wr_en) cnt_d = cnt_q - ONE_V;
        empty_d  = (cnt_d == '0);
        full_d   = (cnt_d == DEPTH_V);
        almost_d = ALMOST_LOW ? (cnt_d <= THR_V) : (cnt_d >= THR_V);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            almost_q <= ALMOST_LOW ? 1'b1 : (ALM_THR == 0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            almost_q <= almost_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o   = empty_q ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign empty_o  = empty_q;
    assign full_o   = full_q;
    assign almost_o = almost_q;

endmodule

// File: rtl/sdk_host_endpoint.sv
// Host-side SDK FIFO endpoint: TX/RX FIFOs, channel-change FSM and sticky error flags.
// Define SDK_EP_STATS_EN to add the tx_words/rx_words word counters.
module sdk_host_endpoint
    import sdk_ep_pkg::*;
#(
    parameter int DW     = SDK_DW,
    parameter int AW     = SDK_AW,
    parameter int AE_LVL = 2,
    parameter int AF_LVL = 2
) (
    input  logic          SDK_CLK,
    input  logic          SDK_RSTN,
    input  logic          h_tx_valid,
    input  logic [DW-1:0] h_tx_data,
    output logic          h_tx_ready,
    output logic          h_rx_valid,
    output logic [DW-1:0] h_rx_data,
    input  logic          h_rx_ready,
    input  logic [7:0]    h_ch,
    input  logic          h_ch_req,
    output logic          h_ch_busy,
    input  logic          h_err_clr,
    output logic          err_underflow,
    output logic          err_overflow,
    output logic [7:0]    SDK_CH,
    input  logic          SDK_RD,
    output logic [DW-1:0] SDK_DI,
    output logic          SDK_AlmostEmpty,
    output logic          SDK_Empty,
    input  logic          SDK_WR,
    input  logic [DW-1:0] SDK_DO,
    output logic          SDK_AlmostFull,
    output logic          SDK_Full
`ifdef SDK_EP_STATS_EN
    ,
    output logic [31:0]   tx_words,
    output logic [31:0]   rx_words
`endif
);

    ch_state_e  state_q, state_d;
    logic [7:0] ch_pend_q, ch_pend_d, ch_q, ch_d;
    logic       unf_q, ovf_q;
    logic       tx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop;

    assign tx_push = h_tx_valid & h_tx_ready;
    assign tx_pop  = SDK_RD & ~SDK_Empty;
    assign rx_push = SDK_WR & ~SDK_Full;
    assign rx_pop  = h_rx_valid & h_rx_ready;

    sdk_sync_fifo #(.DW(DW), .AW(AW), .LVL(AE_LVL), .ALMOST_LOW(1'b1)) u_tx_fifo (
        .clk_i    (SDK_CLK),
        .rst_ni   (SDK_RSTN),
        .push_i   (tx_push),
        .din_i    (h_tx_data),
        .pop_i    (tx_pop),
        .dout_o   (SDK_DI),
        .empty_o  (SDK_Empty),
        .full_o   (tx_full),
        .almost_o (SDK_AlmostEmpty)
    );

    sdk_sync_fifo #(.DW(DW), .AW(AW), .LVL(AF_LVL), .ALMOST_LOW(1'b0)) u_rx_fifo (
        .clk_i    (SDK_CLK),
        .rst_ni   (SDK_RSTN),
        .push_i   (rx_push),
        .din_i    (SDK_DO),
        .pop_i    (rx_pop),
        .dout_o   (h_rx_data),
        .empty_o  (rx_empty),
        .full_o   (SDK_Full),
        .almost_o (SDK_AlmostFull)
    );

    always_comb begin
        state_d   = state_q;
        ch_pend_d = ch_pend_q;
        ch_d      = ch_q;
        unique case (state_q)
            ST_IDLE: if (h_ch_req) begin
                state_d   = ST_WAIT;
                ch_pend_d = h_ch;
            end
            ST_WAIT: if (SDK_Empty && rx_empty) state_d = ST_SWITCH;
            ST_SWITCH: begin
                ch_d    = ch_pend_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
        if (!SDK_RSTN) begin
            state_q   <= ST_IDLE;
            ch_pend_q <= '0;
            ch_q      <= '0;
            unf_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_pend_q <= ch_pend_d;
            ch_q      <= ch_d;
            // A fresh error in the clearing cycle keeps its flag set.
            unf_q     <= (SDK_RD & SDK_Empty) | (unf_q & ~h_err_clr);
            ovf_q     <= (SDK_WR & SDK_Full)  | (ovf_q & ~h_err_clr);
        end
    end

    assign h_ch_busy     = (state_q != ST_IDLE);
    assign h_tx_ready    = ~tx_full & ~h_ch_busy;
    assign h_rx_valid    = ~rx_empty;
    assign SDK_CH        = ch_q;
    assign err_underflow = unf_q;
    assign err_overflow  = ovf_q;

`ifdef SDK_EP_STATS_EN
    logic [31:0] tx_words_q, rx_words_q;

    always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
        if (!SDK_RSTN) begin
            tx_words_q <= '0;
            rx_words_q <= '0;
        end else if (h_err_clr) begin
            tx_words_q <= '0;
            rx_words_q <= '0;
        end else begin
            if (tx_pop)  tx_words_q <= tx_words_q + 32'd1;
            if (rx_push) rx_words_q <= rx_words_q + 32'd1;
        end
    end

    assign tx_words = tx_words_q;
    assign rx_words = rx_words_q;
`endif

endmodule

// File: tb/tb_sdk_host_endpoint.sv
// Directed self-checking bench for sdk_host_endpoint (default DW=16, AW=4, AE/AF=2).
`timescale 1ns/1ps
module tb_sdk_host_endpoint;

    logic        clk = 1'b0;
    logic        rstn;
    logic        h_tx_valid, h_tx_ready, h_rx_valid, h_rx_ready;
    logic [15:0] h_tx_data, h_rx_data;
    logic [7:0]  h_ch, sdk_ch;
    logic        h_ch_req, h_ch_busy, h_err_clr, err_unf, err_ovf;
    logic        sdk_rd, sdk_wr, sdk_ae, sdk_empty, sdk_af, sdk_full;
    logic [15:0] sdk_di, sdk_do;
`ifdef SDK_EP_STATS_EN
    logic [31:0] tx_words, rx_words;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdk_host_endpoint dut (
        .SDK_CLK        (clk),
        .SDK_RSTN       (rstn),
        .h_tx_valid     (h_tx_valid),
        .h_tx_data      (h_tx_data),
        .h_tx_ready     (h_tx_ready),
        .h_rx_valid     (h_rx_valid),
        .h_rx_data      (h_rx_data),
        .h_rx_ready     (h_rx_ready),
        .h_ch           (h_ch),
        .h_ch_req       (h_ch_req),
        .h_ch_busy      (h_ch_busy),
        .h_err_clr      (h_err_clr),
        .err_underflow  (err_unf),
        .err_overflow   (err_ovf),
        .SDK_CH         (sdk_ch),
        .SDK_RD         (sdk_rd),
        .SDK_DI         (sdk_di),
        .SDK_AlmostEmpty(sdk_ae),
        .SDK_Empty      (sdk_empty),
        .SDK_WR         (sdk_wr),
        .SDK_DO         (sdk_do),
        .SDK_AlmostFull (sdk_af),
        .SDK_Full       (sdk_full)
`ifdef SDK_EP_STATS_EN
        ,
        .tx_words       (tx_words),
        .rx_words       (rx_words)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks every output against its reset value; used after power-on and mid-transfer reset.
    task automatic test_reset(input string tag);
        n_chk++;
        if ({sdk_empty, sdk_ae, sdk_full, sdk_af} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s flags: got E/AE/F/AF=%b expected 1100", tag, {sdk_empty, sdk_ae, sdk_full, sdk_af});
        end
        n_chk++;
        if (sdk_di !== 16'h0000) begin
            n_fail++; $display("FAIL %s SDK_DI: got %h expected 0000", tag, sdk_di);
        end
        n_chk++;
        if (h_rx_data !== 16'h0000) begin
            n_fail++; $display("FAIL %s h_rx_data: got %h expected 0000", tag, h_rx_data);
        end
        n_chk++;
        if ({h_tx_ready, h_rx_valid, h_ch_busy} !== 3'b100) begin
            n_fail++; $display("FAIL %s ready/valid/busy: got %b expected 100", tag, {h_tx_ready, h_rx_valid, h_ch_busy});
        end
        n_chk++;
        if (sdk_ch !== 8'h00) begin
            n_fail++; $display("FAIL %s SDK_CH: got %h expected 00", tag, sdk_ch);
        end
        n_chk++;
        if ({err_unf, err_ovf} !== 2'b00) begin
            n_fail++; $display("FAIL %s errors: got %b expected 00", tag, {err_unf, err_ovf});
        end
`ifdef SDK_EP_STATS_EN
        n_chk++;
        if ({tx_words, rx_words} !== 64'd0) begin
            n_fail++; $display("FAIL %s counters: got tx=%0d rx=%0d expected 0", tag, tx_words, rx_words);
        end
`endif
    endtask

    task automatic test_tx_fill;
        for (int i = 1; i <= 16; i++) begin
            h_tx_valid = 1'b1;
            h_tx_data  = 16'(i);
            n_chk++;
            if (h_tx_ready !== 1'b1) begin
                n_fail++; $display("FAIL tx_fill ready word %0d: got %b expected 1", i, h_tx_ready);
            end
            tick;
            if (i == 1) begin
                n_chk++;
                if (sdk_di !== 16'h0001) begin
                    n_fail++; $display("FAIL tx_fill first head: got %h expected 0001", sdk_di);
                end
            end
        end
        h_tx_valid = 1'b0;
        n_chk++;
        if ({h_tx_ready, sdk_full, sdk_empty, sdk_ae} !== 4'b0000) begin
            n_fail++; $display("FAIL tx_fill full flags: got rdy/F/E/AE=%b expected 0000", {h_tx_ready, sdk_full, sdk_empty, sdk_ae});
        end
        n_chk++;
        if (sdk_di !== 16'h0001) begin
            n_fail++; $display("FAIL tx_fill head: got %h expected 0001", sdk_di);
        end
    endtask

    task automatic test_tx_drain;
        sdk_rd = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick;
            n_chk++;
            if (sdk_di !== 16'(k + 1)) begin
                n_fail++; $display("FAIL tx_drain head after pop %0d: got %h expected %h", k, sdk_di, 16'(k + 1));
            end
            n_chk++;
            if ({sdk_empty, sdk_ae} !== {1'b0, (16 - k) <= 2}) begin
                n_fail++; $display("FAIL tx_drain E/AE after pop %0d: got %b expected %b", k, {sdk_empty, sdk_ae}, {1'b0, (16 - k) <= 2});
            end
        end
        tick;
        sdk_rd = 1'b0;
        n_chk++;
        if ({sdk_empty, sdk_ae, h_tx_ready, err_unf} !== 4'b1110) begin
            n_fail++; $display("FAIL tx_drain empty: got E/AE/rdy/unf=%b expected 1110", {sdk_empty, sdk_ae, h_tx_ready, err_unf});
        end
    endtask

    task automatic test_underflow;
        sdk_rd = 1'b1;
        tick;
        sdk_rd = 1'b0;
        n_chk++;
        if ({err_unf, sdk_empty} !== 2'b11) begin
            n_fail++; $display("FAIL underflow set: got unf/E=%b expected 11", {err_unf, sdk_empty});
        end
        // A single push must land at the head and give count 1 if pointers stayed put.
        h_tx_valid = 1'b1; h_tx_data = 16'h1234;
        tick;
        h_tx_valid = 1'b0;
        n_chk++;
        if ({sdk_di, sdk_empty, sdk_ae} !== {16'h1234, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL underflow ptrs: got DI=%h E=%b AE=%b expected 1234/0/1", sdk_di, sdk_empty, sdk_ae);
        end
        sdk_rd = 1'b1;
        tick;
        sdk_rd = 1'b0;
        n_chk++;
        if ({sdk_empty, err_unf} !== 2'b11) begin
            n_fail++; $display("FAIL underflow pop: got E/unf=%b expected 11", {sdk_empty, err_unf});
        end
        sdk_rd = 1'b1; h_err_clr = 1'b1;
        tick;
        sdk_rd = 1'b0;
        n_chk++;
        if (err_unf !== 1'b1) begin
            n_fail++; $display("FAIL underflow clr_vs_set: got %b expected 1", err_unf);
        end
        tick;
        h_err_clr = 1'b0;
        n_chk++;
        if (err_unf !== 1'b0) begin
            n_fail++; $display("FAIL underflow clear: got %b expected 0", err_unf);
        end
    endtask

    task automatic test_overflow;
        sdk_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sdk_do = 16'hA000 + 16'(i);
            tick;
            n_chk++;
            if ({sdk_full, sdk_af} !== {i == 15, (i + 1) >= 14}) begin
                n_fail++; $display("FAIL overflow F/AF after write %0d: got %b expected %b", i, {sdk_full, sdk_af}, {i == 15, (i + 1) >= 14});
            end
        end
        sdk_do = 16'hBEEF;
        tick;
        sdk_wr = 1'b0;
        n_chk++;
        if ({err_ovf, sdk_full, h_rx_valid} !== 3'b111) begin
            n_fail++; $display("FAIL overflow set: got ovf/F/valid=%b expected 111", {err_ovf, sdk_full, h_rx_valid});
        end
        h_rx_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            n_chk++;
            if ({h_rx_valid, h_rx_data} !== {1'b1, 16'hA000 + 16'(j)}) begin
                n_fail++; $display("FAIL overflow rx word %0d: got v=%b %h expected 1 %h", j, h_rx_valid, h_rx_data, 16'hA000 + 16'(j));
            end
            tick;
        end
        h_rx_ready = 1'b0;
        n_chk++;
        if ({h_rx_valid, sdk_full, sdk_af} !== 3'b000) begin
            n_fail++; $display("FAIL overflow drained: got valid/F/AF=%b expected 000", {h_rx_valid, sdk_full, sdk_af});
        end
        h_err_clr = 1'b1;
        tick;
        h_err_clr = 1'b0;
        n_chk++;
        if (err_ovf !== 1'b0) begin
            n_fail++; $display("FAIL overflow clear: got %b expected 0", err_ovf);
        end
    endtask

    task automatic test_channel;
        h_tx_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            h_tx_data = 16'h0100 + 16'(i);
            tick;
        end
        h_tx_valid = 1'b0;
        h_ch = 8'h05; h_ch_req = 1'b1;
        tick;
        h_ch_req = 1'b0; h_ch = 8'h33;
        n_chk++;
        if ({h_ch_busy, h_tx_ready, sdk_ch} !== {2'b10, 8'h00}) begin
            n_fail++; $display("FAIL channel wait: got busy/rdy=%b CH=%h expected 10/00", {h_ch_busy, h_tx_ready}, sdk_ch);
        end
        h_ch_req = 1'b1;
        tick;
        h_ch_req = 1'b0;
        sdk_rd = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            n_chk++;
            if ({h_ch_busy, sdk_ch} !== {1'b1, 8'h00}) begin
                n_fail++; $display("FAIL channel pop %0d: got busy=%b CH=%h expected 1/00", k, h_ch_busy, sdk_ch);
            end
        end
        sdk_rd = 1'b0;
        tick;
        n_chk++;
        if ({h_ch_busy, sdk_ch} !== {1'b1, 8'h00}) begin
            n_fail++; $display("FAIL channel switch: got busy=%b CH=%h expected 1/00", h_ch_busy, sdk_ch);
        end
        tick;
        n_chk++;
        if ({h_ch_busy, h_tx_ready, sdk_ch, err_unf} !== {2'b01, 8'h05, 1'b0}) begin
            n_fail++; $display("FAIL channel done: got busy/rdy=%b CH=%h unf=%b expected 01/05/0", {h_ch_busy, h_tx_ready}, sdk_ch, err_unf);
        end
    endtask

    task automatic test_reset_mid;
        h_err_clr = 1'b1;
        tick;
        h_err_clr = 1'b0;
        h_tx_valid = 1'b1; sdk_wr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            h_tx_data = 16'h0200 + 16'(i);
            sdk_do    = 16'hC000 + 16'(i);
            tick;
        end
        h_tx_valid = 1'b0; sdk_wr = 1'b0;
        n_chk++;
        if ({sdk_di, h_rx_data, sdk_empty, h_rx_valid} !== {16'h0201, 16'hC001, 2'b01}) begin
            n_fail++; $display("FAIL mid_reset preload: got DI=%h RX=%h E=%b V=%b expected 0201/C001/0/1", sdk_di, h_rx_data, sdk_empty, h_rx_valid);
        end
`ifdef SDK_EP_STATS_EN
        n_chk++;
        if ({tx_words, rx_words} !== {32'd0, 32'd8}) begin
            n_fail++; $display("FAIL mid_reset counters: got tx=%0d rx=%0d expected 0/8", tx_words, rx_words);
        end
`endif
        #2 rstn = 1'b0;
        #1;
        test_reset("mid_reset");
        #2 rstn = 1'b1;
        tick;
        n_chk++;
        if ({sdk_empty, h_rx_valid} !== 2'b10) begin
            n_fail++; $display("FAIL mid_reset discard: got E/V=%b expected 10", {sdk_empty, h_rx_valid});
        end
    endtask

    initial begin
        rstn = 1'b0;
        h_tx_valid = 1'b0; h_tx_data = '0; h_rx_ready = 1'b0;
        h_ch = '0; h_ch_req = 1'b0; h_err_clr = 1'b0;
        sdk_rd = 1'b0; sdk_wr = 1'b0; sdk_do = '0;
        tick;
        tick;
        test_reset("reset");
        rstn = 1'b1;
        tick;
        test_tx_fill;
        test_tx_drain;
        test_underflow;
        test_overflow;
        test_channel;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
